md_mode_pingpong_buf: RTL and testbench
=======================================

// Module: md_mode_pingpong_buf
// PURPOSE
//  Receive-side store for the pre-intra mode write stream (md_we/md_waddr/md_wdata).
//  Holds the mode set of one LCU in each of two banks (ping-pong).
//  Serves random-access reads to the downstream intra/RDO stage while the next LCU's
//  modes are being written.
//  Tracks which entries were written; a read of an unwritten entry returns DEFAULT_MODE.
// PARAMETERS
//  DEPTH         128  entries per bank (7-bit address; md_waddr is never out of range)
//  DW            6    mode width
//  DEFAULT_MODE  1    value returned for unwritten entries (DC)
// PORTS
//  clk            in   1   clock; all logic on rising edge
//  rstn           in   1   synchronous, active-high reset
//  md_we          in   1   mode write strobe from pre-intra
//  md_waddr       in   7   mode write address
//  md_wdata       in   6   mode value
//  md_finish_i    in   1   1-cycle pulse: current LCU's mode set is complete
//  md_wr_rdy_o    out  1   write bank is FREE; writes and finish are accepted
//  rd_lcu_vld_o   out  1   read bank is FULL; reads are allowed
//  rd_en_i        in   1   read request
//  rd_addr_i      in   7   read address
//  rd_dval_o      out  1   rd_data_o/rd_hit_o valid (1 cycle after accepted rd_en_i)
//  rd_data_o      out  6   mode read
//  rd_hit_o       out  1   entry was written in this LCU
//  rd_release_i   in   1   1-cycle pulse: reader done with current bank
//  ovf_o          out  1   sticky: write or finish dropped because md_wr_rdy_o=0
// BEHAVIOUR
//  State
//   - Per-bank state bst[b] in {FREE, FULL}.
//   - wr_ptr and rd_ptr are 1-bit pointers.
//   - Per-bank 128-bit valid map vmap[b].
//  Reset
//   - bst = FREE, wr_ptr = rd_ptr = 0, vmap cleared.
//   - rd_dval_o, rd_data_o, rd_hit_o, ovf_o = 0.
//   - md_wr_rdy_o = 1 and rd_lcu_vld_o = 0 (both decoded combinationally from state).
//   - Reset mid-LCU discards both banks; no partial data survives.
//  Write side
//   - md_wr_rdy_o = (bst[wr_ptr] == FREE).
//   - md_we & rdy: mem[wr_ptr][md_waddr] <= md_wdata; vmap[wr_ptr][md_waddr] <= 1.
//   - Repeated writes to the same address: last write wins.
//   - md_finish_i & rdy: bst[wr_ptr] <= FULL; wr_ptr toggles.
//   - md_we and md_finish_i in the same cycle: the write lands in the bank being closed.
//   - md_we or md_finish_i while !rdy: ignored (no memory or state change); ovf_o <= 1.
//   - ovf_o clears only on reset.
//  Read side
//   - rd_lcu_vld_o = (bst[rd_ptr] == FULL).
//   - rd_en_i & vld: next cycle rd_dval_o = 1.
//     - rd_hit_o = vmap[rd_ptr][rd_addr_i].
//     - rd_data_o = hit ? mem : DEFAULT_MODE.
//   - Read latency is exactly 1; one read accepted per cycle; back-to-back reads supported.
//   - rd_en_i while !vld: ignored; rd_dval_o = 0 next cycle.
//   - When no read was accepted, rd_data_o and rd_hit_o hold their last values.
//   - rd_release_i & vld: bst[rd_ptr] <= FREE; vmap[rd_ptr] cleared in one cycle; rd_ptr toggles.
//   - rd_release_i while !vld: ignored.
//   - rd_en_i and rd_release_i in the same cycle: the read uses the old bank and its data
//     appears next cycle; the release then takes effect.
//  Simultaneous events
//   - md_finish_i and rd_release_i in the same cycle act on different banks; both take effect.
//   - A bank freed this cycle becomes writable next cycle (md_wr_rdy_o rises 1 cycle after release).
//   - A bank made FULL this cycle: rd_lcu_vld_o rises the next cycle.
//   - No write-to-read bypass; at least 1 cycle separates finish and the first read.
//  Memory
//   - 2 x DEPTH x DW, synchronous read, one write port and one read port.
//   - Write and read can never target the same bank in the same cycle.
// TESTING
//  1. Reset; write addr 0..84 with value addr%35; finish.
//     -> rd_lcu_vld_o = 1 next cycle; read addr 5 -> data 5, hit 1, rd_dval_o exactly 1 cycle later.
//  2. After test 1, read addr 100 (unwritten) -> data 1, hit 0.
//     Write addr 3 twice (7, then 9) in the next LCU -> a read of that LCU returns 9.
//  3. Fill and finish two LCUs without release -> md_wr_rdy_o = 0.
//     A third md_we is dropped and ovf_o = 1.
//     Release -> md_wr_rdy_o = 1 one cycle later; ovf_o stays 1.
//  4. Same cycle md_finish_i (bank1) and rd_release_i (bank0) -> both applied.
//     Reads then return bank1 contents; bank0 is writable.
//  5. rd_en_i + rd_release_i same cycle (addr 10) -> old-bank data delivered.
//     With no FULL bank, a subsequent rd_en_i gives rd_dval_o = 0.
//  6. Assert rstn mid-write (40 entries written) -> all outputs at reset values.
//     Reads blocked; after a new LCU, addr 20 unwritten -> hit 0.

Source files
------------

// File: rtl/md_mode_pingpong_buf.sv
// Two-bank (ping-pong) store for per-LCU intra mode sets with a per-entry written map.
// Unwritten entries read back as DEFAULT_MODE; read latency is one cycle.
module md_mode_pingpong_buf #(
    parameter int             DEPTH        = 128,
    parameter int             DW           = 6,
    parameter logic [DW-1:0]  DEFAULT_MODE = DW'(1),
    parameter int             AW           = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          md_we,
    input  logic [AW-1:0] md_waddr,
    input  logic [DW-1:0] md_wdata,
    input  logic          md_finish_i,
    output logic          md_wr_rdy_o,
    output logic          rd_lcu_vld_o,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic          rd_dval_o,
    output logic [DW-1:0] rd_data_o,
    output logic          rd_hit_o,
    input  logic          rd_release_i,
    output logic          ovf_o
);

    typedef enum logic {FREE = 1'b0, FULL = 1'b1} bank_st_e;

    bank_st_e         bst_q  [2];
    bank_st_e         bst_d  [2];
    logic [DEPTH-1:0] vmap_q [2];
    logic [DEPTH-1:0] vmap_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic             ovf_q, ovf_d;
    logic             rd_dval_q, rd_dval_d;
    logic             rd_hit_q, rd_hit_d;
    logic             rd_any_q, rd_any_d;

    logic [DW-1:0]    mem [2*DEPTH];
    logic [DW-1:0]    rd_word_q;

    logic we_acc, fin_acc, rd_acc, rel_acc;

    assign md_wr_rdy_o  = (bst_q[wr_ptr_q] == FREE);
    assign rd_lcu_vld_o = (bst_q[rd_ptr_q] == FULL);

    assign we_acc  = md_we        & md_wr_rdy_o;
    assign fin_acc = md_finish_i  & md_wr_rdy_o;
    assign rd_acc  = rd_en_i      & rd_lcu_vld_o;
    assign rel_acc = rd_release_i & rd_lcu_vld_o;

    // Write and release always address different banks, so their updates never collide.
    always_comb begin
        bst_d     = bst_q;
        vmap_d    = vmap_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ovf_d     = ovf_q | ((md_we | md_finish_i) & ~md_wr_rdy_o);
        rd_dval_d = rd_acc;
        rd_hit_d  = rd_hit_q;
        rd_any_d  = rd_any_q | rd_acc;
        if (we_acc) begin
            vmap_d[wr_ptr_q][md_waddr] = 1'b1;
        end
        if (fin_acc) begin
            bst_d[wr_ptr_q] = FULL;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (rd_acc) begin
            rd_hit_d = vmap_q[rd_ptr_q][rd_addr_i];
        end
        if (rel_acc) begin
            bst_d[rd_ptr_q]  = FREE;
            vmap_d[rd_ptr_q] = '0;
            rd_ptr_d         = ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            for (int b = 0; b < 2; b++) begin
                bst_q[b]  <= FREE;
                vmap_q[b] <= '0;
            end
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            ovf_q     <= 1'b0;
            rd_dval_q <= 1'b0;
            rd_hit_q  <= 1'b0;
            rd_any_q  <= 1'b0;
        end else begin
            bst_q     <= bst_d;
            vmap_q    <= vmap_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ovf_q     <= ovf_d;
            rd_dval_q <= rd_dval_d;
            rd_hit_q  <= rd_hit_d;
            rd_any_q  <= rd_any_d;
        end
    end

    // Plain RAM with registered read; stale contents are masked by the valid map.
    always_ff @(posedge clk) begin
        if (we_acc) begin
            mem[{wr_ptr_q, md_waddr}] <= md_wdata;
        end
        if (rd_acc) begin
            rd_word_q <= mem[{rd_ptr_q, rd_addr_i}];
        end
    end

    assign rd_dval_o = rd_dval_q;
    assign rd_hit_o  = rd_hit_q;
    assign ovf_o     = ovf_q;
    // rd_any_q keeps the data output at zero until the first read after reset.
    assign rd_data_o = !rd_any_q ? '0 : (rd_hit_q ? rd_word_q : DEFAULT_MODE);

endmodule

// File: tb/tb_md_mode_pingpong_buf.sv
// Directed bench for md_mode_pingpong_buf: linear steps with hand-computed expectations.
module tb_md_mode_pingpong_buf;

    logic       clk = 1'b0;
    logic       rstn;
    logic       md_we;
    logic [6:0] md_waddr;
    logic [5:0] md_wdata;
    logic       md_finish_i;
    logic       md_wr_rdy_o;
    logic       rd_lcu_vld_o;
    logic       rd_en_i;
    logic [6:0] rd_addr_i;
    logic       rd_dval_o;
    logic [5:0] rd_data_o;
    logic       rd_hit_o;
    logic       rd_release_i;
    logic       ovf_o;

    int n_chk  = 0;
    int n_fail = 0;

    md_mode_pingpong_buf dut (
        .clk          (clk),
        .rstn         (rstn),
        .md_we        (md_we),
        .md_waddr     (md_waddr),
        .md_wdata     (md_wdata),
        .md_finish_i  (md_finish_i),
        .md_wr_rdy_o  (md_wr_rdy_o),
        .rd_lcu_vld_o (rd_lcu_vld_o),
        .rd_en_i      (rd_en_i),
        .rd_addr_i    (rd_addr_i),
        .rd_dval_o    (rd_dval_o),
        .rd_data_o    (rd_data_o),
        .rd_hit_o     (rd_hit_o),
        .rd_release_i (rd_release_i),
        .ovf_o        (ovf_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [6:0] a, input logic [5:0] d);
        md_we = 1'b1; md_waddr = a; md_wdata = d;
        tick();
        md_we = 1'b0;
    endtask

    task automatic fin();
        md_finish_i = 1'b1;
        tick();
        md_finish_i = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [6:0] a, input logic [5:0] d, input logic h);
        rd_en_i = 1'b1; rd_addr_i = a;
        tick();
        rd_en_i = 1'b0;
        chk({tag, "_dval"}, 8'(rd_dval_o), 8'd1);
        chk({tag, "_data"}, 8'(rd_data_o), 8'(d));
        chk({tag, "_hit"},  8'(rd_hit_o),  8'(h));
        $display("read %s addr=%0d data=%0d hit=%0d", tag, a, rd_data_o, rd_hit_o);
    endtask

    initial begin
        rstn = 1'b1; md_we = 1'b0; md_waddr = '0; md_wdata = '0; md_finish_i = 1'b0;
        rd_en_i = 1'b0; rd_addr_i = '0; rd_release_i = 1'b0;
        tick(); tick();
        rstn = 1'b0;
        chk("rst_rdy",  8'(md_wr_rdy_o),  8'd1);
        chk("rst_vld",  8'(rd_lcu_vld_o), 8'd0);
        chk("rst_dval", 8'(rd_dval_o),    8'd0);
        chk("rst_data", 8'(rd_data_o),    8'd0);
        chk("rst_hit",  8'(rd_hit_o),     8'd0);
        chk("rst_ovf",  8'(ovf_o),        8'd0);

        // Test 1: fill bank0 with addr%35, finish, read back
        for (int i = 0; i < 85; i++) wr(7'(i), 6'(i % 35));
        chk("t1_vld_before_fin", 8'(rd_lcu_vld_o), 8'd0);
        fin();
        chk("t1_vld_after_fin", 8'(rd_lcu_vld_o), 8'd1);
        chk("t1_rdy_after_fin", 8'(md_wr_rdy_o),  8'd1);
        rd("t1_a5", 7'd5, 6'd5, 1'b1);
        tick();
        chk("t1_dval_one_cycle", 8'(rd_dval_o), 8'd0);
        chk("t1_data_hold",      8'(rd_data_o), 8'd5);

        // Test 2: unwritten read, last-write-wins in next LCU
        rd("t2_a100", 7'd100, 6'd1, 1'b0);
        rd("t2_a84",  7'd84,  6'd14, 1'b1);
        wr(7'd3, 6'd7);
        wr(7'd3, 6'd9);
        fin();
        chk("t2_rdy_both_full", 8'(md_wr_rdy_o), 8'd0);
        rd_release_i = 1'b1; tick(); rd_release_i = 1'b0;
        chk("t2_vld_bank1", 8'(rd_lcu_vld_o), 8'd1);
        rd("t2_a3",  7'd3, 6'd9, 1'b1);
        rd("t2_a5",  7'd5, 6'd1, 1'b0);

        // Test 3: both banks full, dropped write sets ovf, release frees a bank
        wr(7'd10, 6'd33);
        wr(7'd20, 6'd22);
        fin();
        chk("t3_rdy_full", 8'(md_wr_rdy_o), 8'd0);
        chk("t3_ovf_pre",  8'(ovf_o),       8'd0);
        wr(7'd10, 6'd5);
        chk("t3_ovf_set",  8'(ovf_o),       8'd1);
        fin();
        chk("t3_rdy_after_drop_fin", 8'(md_wr_rdy_o), 8'd0);
        rd_release_i = 1'b1;
        chk("t3_rdy_before_rel", 8'(md_wr_rdy_o), 8'd0);
        tick(); rd_release_i = 1'b0;
        chk("t3_rdy_after_rel", 8'(md_wr_rdy_o), 8'd1);
        chk("t3_ovf_sticky",    8'(ovf_o),       8'd1);
        rd("t3_a10", 7'd10, 6'd33, 1'b1);
        rd("t3_a20", 7'd20, 6'd22, 1'b1);

        // Test 4: write+finish into bank1 together with release of bank0
        wr(7'd7, 6'd44);
        md_we = 1'b1; md_waddr = 7'd10; md_wdata = 6'd12;
        md_finish_i = 1'b1; rd_release_i = 1'b1;
        tick();
        md_we = 1'b0; md_finish_i = 1'b0; rd_release_i = 1'b0;
        chk("t4_vld", 8'(rd_lcu_vld_o), 8'd1);
        chk("t4_rdy", 8'(md_wr_rdy_o),  8'd1);
        rd("t4_a7",  7'd7,  6'd44, 1'b1);
        rd("t4_a10", 7'd10, 6'd12, 1'b1);
        rd("t4_a20", 7'd20, 6'd1,  1'b0);

        // Test 5: read and release in the same cycle, then a blocked read
        rd_release_i = 1'b1;
        rd("t5_a10", 7'd10, 6'd12, 1'b1);
        rd_release_i = 1'b0;
        chk("t5_vld_gone", 8'(rd_lcu_vld_o), 8'd0);
        rd_en_i = 1'b1; rd_addr_i = 7'd7;
        tick();
        rd_en_i = 1'b0;
        chk("t5_blocked_dval", 8'(rd_dval_o), 8'd0);
        chk("t5_data_held",    8'(rd_data_o), 8'd12);
        chk("t5_hit_held",     8'(rd_hit_o),  8'd1);

        // Test 6: reset in the middle of an LCU
        for (int i = 0; i < 40; i++) wr(7'(i), 6'(i));
        md_we = 1'b1; md_waddr = 7'd40; md_wdata = 6'd40;
        rstn = 1'b1;
        tick();
        rstn = 1'b0; md_we = 1'b0;
        chk("t6_rdy",  8'(md_wr_rdy_o),  8'd1);
        chk("t6_vld",  8'(rd_lcu_vld_o), 8'd0);
        chk("t6_dval", 8'(rd_dval_o),    8'd0);
        chk("t6_data", 8'(rd_data_o),    8'd0);
        chk("t6_hit",  8'(rd_hit_o),     8'd0);
        chk("t6_ovf",  8'(ovf_o),        8'd0);
        rd_en_i = 1'b1; rd_addr_i = 7'd5;
        tick();
        rd_en_i = 1'b0;
        chk("t6_blocked_dval", 8'(rd_dval_o), 8'd0);
        wr(7'd21, 6'd3);
        fin();
        rd("t6_a20", 7'd20, 6'd1, 1'b0);
        rd("t6_a21", 7'd21, 6'd3, 1'b1);
        rd("t6_a5",  7'd5,  6'd1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
